// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: alucodes, FSM states, access sizes and decode helpers.
package load_store_unit_pkg;

    localparam logic [5:0] ALU_LB  = 6'd20;
    localparam logic [5:0] ALU_LH  = 6'd21;
    localparam logic [5:0] ALU_LW  = 6'd22;
    localparam logic [5:0] ALU_LBU = 6'd23;
    localparam logic [5:0] ALU_LHU = 6'd24;
    localparam logic [5:0] ALU_SB  = 6'd25;
    localparam logic [5:0] ALU_SH  = 6'd26;
    localparam logic [5:0] ALU_SW  = 6'd27;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B    = 2'd0,
        SZ_H    = 2'd1,
        SZ_W    = 2'd2,
        SZ_NONE = 2'd3
    } lsu_size_e;

    function automatic lsu_size_e code_size(input logic [5:0] code);
        lsu_size_e sz;
        case (code)
            ALU_LB, ALU_LBU, ALU_SB: sz = SZ_B;
            ALU_LH, ALU_LHU, ALU_SH: sz = SZ_H;
            ALU_LW, ALU_SW:          sz = SZ_W;
            default:                 sz = SZ_NONE;
        endcase
        return sz;
    endfunction

    function automatic logic code_is_store(input logic [5:0] code);
        return (code == ALU_SB) || (code == ALU_SH) || (code == ALU_SW);
    endfunction

    function automatic logic code_is_signed(input logic [5:0] code);
        return (code == ALU_LB) || (code == ALU_LH);
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: byte-enable / store-lane steering and load extraction with sign or zero extension.
// Optional misalignment detection is compiled in with LSU_MISALIGN_TRAP_EN.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [5:0]  code_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic        is_mem_o,
    output logic        is_store_o,
    output logic        misalign_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    lsu_size_e   size;
    logic [31:0] byte_rep;
    logic [31:0] half_rep;
    logic [7:0]  rbyte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        sign_ext;

    assign size       = code_size(code_i);
    assign is_mem_o   = (size != SZ_NONE);
    assign is_store_o = code_is_store(code_i);
    assign sign_ext   = code_is_signed(code_i);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_rep[8*gi +: 8] = wdata_i[7:0];
            assign half_rep[8*gi +: 8] = wdata_i[8*(gi%2) +: 8];
            assign rbyte[gi]           = rdata_i[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = rbyte[addr_lo_i];
    assign sel_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        rdata_o = 32'h0;
        case (size)
            SZ_B: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = byte_rep;
                rdata_o = {{24{sign_ext & sel_byte[7]}}, sel_byte};
            end
            SZ_H: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = half_rep;
                rdata_o = {{16{sign_ext & sel_half[15]}}, sel_half};
            end
            SZ_W: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_o = ((size == SZ_H) && addr_lo_i[0]) ||
                        ((size == SZ_W) && (addr_lo_i != 2'b00));
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: req/ack data-memory transaction between execute and writeback.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses without touching memory.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_alucode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        rsp_misalign
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W:0] TIMEOUT_V = (CNT_W + 1)'(ACK_TIMEOUT);

    lsu_state_e  state_q;
    logic [5:0]  code_q;
    logic [1:0]  addr_lo_q;
    logic        dmem_req_q;
    logic        dmem_we_q;
    logic [31:0] dmem_addr_q;
    logic [3:0]  dmem_be_q;
    logic [31:0] dmem_wdata_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;
    logic        rsp_misalign_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0]   cnt_d;

    logic [5:0]  sel_code;
    logic [1:0]  sel_addr_lo;
    logic        al_is_mem;
    logic        al_is_store;
    logic        al_misalign;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;

    // In IDLE the aligner decodes the incoming request; afterwards the latched op drives extraction.
    assign sel_code    = (state_q == ST_IDLE) ? req_alucode     : code_q;
    assign sel_addr_lo = (state_q == ST_IDLE) ? req_addr[1:0]   : addr_lo_q;

    lsu_align u_align (
        .code_i     (sel_code),
        .addr_lo_i  (sel_addr_lo),
        .wdata_i    (req_wdata),
        .rdata_i    (dmem_rdata),
        .is_mem_o   (al_is_mem),
        .is_store_o (al_is_store),
        .misalign_o (al_misalign),
        .be_o       (al_be),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata)
    );

    assign cnt_d = {1'b0, cnt_q} + (CNT_W + 1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            code_q         <= 6'd0;
            addr_lo_q      <= 2'b00;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= 32'h0;
            dmem_be_q      <= 4'h0;
            dmem_wdata_q   <= 32'h0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= 32'h0;
            rsp_err_q      <= 1'b0;
            rsp_misalign_q <= 1'b0;
            cnt_q          <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && al_is_mem) begin
                        code_q    <= req_alucode;
                        addr_lo_q <= req_addr[1:0];
                        cnt_q     <= '0;
                        if (al_misalign) begin
                            state_q        <= ST_RESP;
                            rsp_valid_q    <= 1'b1;
                            rsp_data_q     <= 32'h0;
                            rsp_err_q      <= 1'b1;
                            rsp_misalign_q <= 1'b1;
                        end else begin
                            state_q      <= ST_ACCESS;
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= al_is_store;
                            dmem_addr_q  <= {req_addr[31:2], 2'b00};
                            dmem_be_q    <= al_be;
                            dmem_wdata_q <= al_wdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ack) begin
                        state_q        <= ST_RESP;
                        dmem_req_q     <= 1'b0;
                        rsp_valid_q    <= 1'b1;
                        rsp_data_q     <= dmem_we_q ? 32'h0 : al_rdata;
                        rsp_err_q      <= 1'b0;
                        rsp_misalign_q <= 1'b0;
                        cnt_q          <= '0;
                    end else if ((ACK_TIMEOUT != 0) && (cnt_d == TIMEOUT_V)) begin
                        state_q        <= ST_RESP;
                        dmem_req_q     <= 1'b0;
                        rsp_valid_q    <= 1'b1;
                        rsp_data_q     <= 32'h0;
                        rsp_err_q      <= 1'b1;
                        rsp_misalign_q <= 1'b0;
                        cnt_q          <= '0;
                    end else begin
                        cnt_q <= cnt_d[CNT_W-1:0];
                    end
                end
                ST_RESP: begin
                    state_q        <= ST_IDLE;
                    rsp_data_q     <= 32'h0;
                    rsp_err_q      <= 1'b0;
                    rsp_misalign_q <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_be      = dmem_be_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_misalign = rsp_misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus timeout and mid-access reset sequences.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready;
    logic [5:0]  req_alucode;
    logic [31:0] req_addr, req_wdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        rsp_valid, rsp_err, rsp_misalign;
    logic [31:0] rsp_data;

    logic        t_req_valid, t_req_ready;
    logic [5:0]  t_req_alucode;
    logic [31:0] t_req_addr, t_req_wdata;
    logic        t_dmem_req, t_dmem_we, t_dmem_ack;
    logic [31:0] t_dmem_addr, t_dmem_wdata, t_dmem_rdata;
    logic [3:0]  t_dmem_be;
    logic        t_rsp_valid, t_rsp_err, t_rsp_misalign;
    logic [31:0] t_rsp_data;

    load_store_unit #(.ACK_TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_alucode(req_alucode),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_misalign(rsp_misalign)
    );

    load_store_unit #(.ACK_TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst),
        .req_valid(t_req_valid), .req_ready(t_req_ready), .req_alucode(t_req_alucode),
        .req_addr(t_req_addr), .req_wdata(t_req_wdata),
        .dmem_req(t_dmem_req), .dmem_we(t_dmem_we), .dmem_addr(t_dmem_addr), .dmem_be(t_dmem_be),
        .dmem_wdata(t_dmem_wdata), .dmem_ack(t_dmem_ack), .dmem_rdata(t_dmem_rdata),
        .rsp_valid(t_rsp_valid), .rsp_data(t_rsp_data), .rsp_err(t_rsp_err), .rsp_misalign(t_rsp_misalign)
    );

    typedef struct {
        logic [5:0]  code;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic        trap;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_we;
        logic [31:0] e_rsp;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        chk("ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_alucode = v.code; req_addr = v.addr; req_wdata = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        if (v.trap) begin
            chk("trap_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("trap_err", 32'(rsp_err), 32'd1);
            chk("trap_misalign", 32'(rsp_misalign), 32'd1);
            chk("trap_data", rsp_data, 32'h0);
            chk("trap_no_dmem_req", 32'(dmem_req), 32'd0);
        end else begin
            chk("dmem_req", 32'(dmem_req), 32'd1);
            chk("dmem_addr", dmem_addr, v.e_addr);
            chk("dmem_be", 32'(dmem_be), 32'(v.e_be));
            chk("dmem_we", 32'(dmem_we), 32'(v.e_we));
            chk("dmem_wdata", dmem_wdata, v.e_wdata);
            for (int n = 0; n < v.delay; n++) begin
                @(negedge clk);
                chk("held_stable", 32'(dmem_req && dmem_addr == v.e_addr && dmem_be == v.e_be &&
                    dmem_we == v.e_we && dmem_wdata == v.e_wdata && !rsp_valid), 32'd1);
            end
            dmem_ack = 1'b1; dmem_rdata = v.rdata;
            @(negedge clk);
            dmem_ack = 1'b0; dmem_rdata = 32'h5A5A5A5A;
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_data", rsp_data, v.e_rsp);
            chk("rsp_err", 32'(rsp_err), 32'd0);
            chk("rsp_misalign", 32'(rsp_misalign), 32'd0);
            chk("dmem_req_drop", 32'(dmem_req), 32'd0);
        end
        $display("vec %0d code=%0d addr=0x%08h be=%b rsp_data=0x%08h err=%b mis=%b",
                 idx, v.code, v.addr, dmem_be, rsp_data, rsp_err, rsp_misalign);
        @(negedge clk);
        chk("rsp_pulse_end", 32'(rsp_valid), 32'd0);
        chk("ready_after", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int acc_cycles;
        int n;

        vecs[0]  = '{ALU_SW,  32'h100, 32'hDEADBEEF, 32'hFFFFFFFF, 1, 1'b0, 32'h100, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0};
        vecs[1]  = '{ALU_LB,  32'h103, 32'h0, 32'h80FF0000, 0, 1'b0, 32'h100, 4'h8, 32'h0, 1'b0, 32'hFFFFFF80};
        vecs[2]  = '{ALU_LBU, 32'h103, 32'h0, 32'h80FF0000, 0, 1'b0, 32'h100, 4'h8, 32'h0, 1'b0, 32'h00000080};
        vecs[3]  = '{ALU_SH,  32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 5, 1'b0, 32'h200, 4'hC, 32'hABCDABCD, 1'b1, 32'h0};
        vecs[4]  = '{ALU_LH,  32'h202, 32'h0, 32'h80011234, 0, 1'b0, 32'h200, 4'hC, 32'h0, 1'b0, 32'hFFFF8001};
        vecs[5]  = '{ALU_LHU, 32'h200, 32'h0, 32'h1234F00D, 2, 1'b0, 32'h200, 4'h3, 32'h0, 1'b0, 32'h0000F00D};
        vecs[6]  = '{ALU_SB,  32'h101, 32'h000000A5, 32'h0, 0, 1'b0, 32'h100, 4'h2, 32'hA5A5A5A5, 1'b1, 32'h0};
        vecs[7]  = '{ALU_LW,  32'h104, 32'h0, 32'hCAFEBABE, 0, 1'b0, 32'h104, 4'hF, 32'h0, 1'b0, 32'hCAFEBABE};
        vecs[8]  = '{ALU_LB,  32'h100, 32'h0, 32'h0000007F, 0, 1'b0, 32'h100, 4'h1, 32'h0, 1'b0, 32'h0000007F};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[9]  = '{ALU_LW,  32'h101, 32'h0, 32'h11223344, 0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0};
        vecs[10] = '{ALU_SH,  32'h203, 32'h0000BEEF, 32'h0, 2, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0};
`else
        vecs[9]  = '{ALU_LW,  32'h101, 32'h0, 32'h11223344, 0, 1'b0, 32'h100, 4'hF, 32'h0, 1'b0, 32'h11223344};
        vecs[10] = '{ALU_SH,  32'h203, 32'h0000BEEF, 32'h0, 2, 1'b0, 32'h200, 4'hC, 32'hBEEFBEEF, 1'b1, 32'h0};
`endif
        vecs[11] = '{ALU_SB,  32'h103, 32'h12345678, 32'h0, 0, 1'b0, 32'h100, 4'h8, 32'h78787878, 1'b1, 32'h0};

        rst = 1'b1;
        req_valid = 1'b0; req_alucode = 6'd0; req_addr = 32'h0; req_wdata = 32'h0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        t_req_valid = 1'b0; t_req_alucode = 6'd0; t_req_addr = 32'h0; t_req_wdata = 32'h0;
        t_dmem_ack = 1'b0; t_dmem_rdata = 32'h0;
        repeat (3) @(negedge clk);

        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_dmem_we", 32'(dmem_we), 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'h0);
        chk("rst_dmem_be", 32'(dmem_be), 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_misalign", 32'(rsp_misalign), 32'd0);
        $display("reset: ready=%b dmem_req=%b rsp_valid=%b", req_ready, dmem_req, rsp_valid);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

        // Non-memory alucode must be ignored entirely.
        @(negedge clk);
        req_valid = 1'b1; req_alucode = 6'd0; req_addr = 32'h400;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (!req_ready || dmem_req || rsp_valid) seen++;
        end
        req_valid = 1'b0;
        chk("nonmem_ignored", 32'(seen), 32'd0);
        $display("nonmem: code=0 ignored events=%0d", seen);

        // Timeout on the ACK_TIMEOUT=4 instance.
        @(negedge clk);
        t_req_valid = 1'b1; t_req_alucode = ALU_LW; t_req_addr = 32'h300;
        @(negedge clk);
        t_req_valid = 1'b0;
        acc_cycles = 0; n = 0;
        while (!t_rsp_valid && n < 20) begin
            if (t_dmem_req) acc_cycles++;
            @(negedge clk);
            n++;
        end
        chk("to_access_cycles", 32'(acc_cycles), 32'd4);
        chk("to_rsp_valid", 32'(t_rsp_valid), 32'd1);
        chk("to_rsp_err", 32'(t_rsp_err), 32'd1);
        chk("to_rsp_misalign", 32'(t_rsp_misalign), 32'd0);
        chk("to_rsp_data", t_rsp_data, 32'h0);
        chk("to_dmem_req", 32'(t_dmem_req), 32'd0);
        $display("timeout: access_cycles=%0d err=%b", acc_cycles, t_rsp_err);
        @(negedge clk);
        chk("to_ready", 32'(t_req_ready), 32'd1);

        // Reset in the middle of an access, followed by a stale ack.
        @(negedge clk);
        req_valid = 1'b1; req_alucode = ALU_LW; req_addr = 32'h500;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid_req", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_drop", 32'(dmem_req), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        chk("rst_mid_be", 32'(dmem_be), 32'd0);
        dmem_ack = 1'b1; dmem_rdata = 32'h99999999;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid || dmem_req) seen++;
            @(negedge clk);
            dmem_ack = 1'b0;
        end
        chk("late_ack_ignored", 32'(seen), 32'd0);
        $display("reset mid-access: stray events=%0d", seen);
        run_vec(NVEC, vecs[7]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
